// File: rtl/fp_adder_pkg.sv
// fp_adder_pkg: shared mantissa width and add/sub opcode for the FP adder datapath
package fp_adder_pkg;
  localparam int MANT_WIDTH = 24;
  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_t;
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/mantissa_adder_segment.sv
// mantissa_adder_segment: combinational SEG-bit ripple adder built from full_adder cells
module mantissa_adder_segment #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] in_a,
  input  logic [SEG-1:0] in_b,
  input  logic           in_carry,
  output logic [SEG-1:0] out,
  output logic           out_carry
);
  logic [SEG:0] c;
  assign c[0] = in_carry;
  for (genvar i = 0; i < SEG; i++) begin : g_fa
    full_adder u_fa (.a(in_a[i]), .b(in_b[i]), .cin(c[i]), .sum(out[i]), .cout(c[i+1]));
  end
  assign out_carry = c[SEG];
endmodule

// File: rtl/pipelined_mantissa_adder.sv
// pipelined_mantissa_adder: add/sub of unsigned mantissas, carry chain split into STAGES registered segments
module pipelined_mantissa_adder
  import fp_adder_pkg::*;
#(
  parameter int WIDTH  = MANT_WIDTH,
  parameter int STAGES = 3
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_carry,
  output logic             out_zero
);
  localparam int NS  = STAGES < 1 ? 1 : STAGES;
  localparam int SEG = WIDTH / NS;
  if (STAGES < 1 || WIDTH % NS != 0) begin : g_bad_params
    $error("pipelined_mantissa_adder: STAGES must be >= 1 and divide WIDTH");
  end
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  // Stage k resolves bits [k*SEG +: SEG]; only the still-unresolved operand bits travel onward.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO  = k * SEG;
    localparam int REM = WIDTH - LO;
    logic [REM-1:0]    a_s, b_s;
    op_t               s_s;
    logic              c_s, v_s;
    logic [LO+SEG-1:0] r_n, r_q;
    logic [SEG-1:0]    seg_r;
    logic              seg_c, v_q, c_q;
    if (k == 0) begin : g_in
      assign a_s = in_a;
      assign b_s = in_b;
      assign s_s = op_t'(in_sub);
      assign c_s = in_sub;
      assign v_s = in_valid;
      assign r_n = seg_r;
    end else begin : g_in
      assign a_s = g_st[k-1].g_fwd.a_q;
      assign b_s = g_st[k-1].g_fwd.b_q;
      assign s_s = g_st[k-1].g_fwd.s_q;
      assign c_s = g_st[k-1].c_q;
      assign v_s = g_st[k-1].v_q;
      assign r_n = {seg_r, g_st[k-1].r_q};
    end
    mantissa_adder_segment #(.SEG(SEG)) u_seg (
      .in_a     (a_s[SEG-1:0]),
      .in_b     (s_s == OP_SUB ? ~b_s[SEG-1:0] : b_s[SEG-1:0]),
      .in_carry (c_s),
      .out      (seg_r),
      .out_carry(seg_c)
    );
    always_ff @(posedge in_clk)
      if (in_rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else if (en) begin
        v_q <= v_s;
        c_q <= seg_c;
        r_q <= r_n;
      end
    if (k < STAGES - 1) begin : g_fwd
      logic [REM-SEG-1:0] a_q, b_q;
      op_t                s_q;
      always_ff @(posedge in_clk)
        if (en) begin
          a_q <= a_s[REM-1:SEG];
          b_q <= b_s[REM-1:SEG];
          s_q <= s_s;
        end
    end
  end
  assign out_valid = g_st[STAGES-1].v_q;
  assign out       = g_st[STAGES-1].r_q;
  assign out_carry = g_st[STAGES-1].c_q;
  assign out_zero  = out_valid && out == '0;
endmodule

// File: tb/tb_pipelined_mantissa_adder.sv
// tb_pipelined_mantissa_adder: directed vectors, stall/reset sequences and a random scoreboard run
module tb_pipelined_mantissa_adder;
  import fp_adder_pkg::*;
  localparam int W = MANT_WIDTH;

  logic         in_clk = 1'b0, in_rst = 1'b1, in_valid = 1'b0, in_sub = 1'b0, out_ready = 1'b1;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic         in_ready, out_valid, out_carry, out_zero;
  logic [W-1:0] out;

  int total = 0, bad = 0, n_out = 0;

  typedef struct {
    logic         sub;
    logic [W-1:0] a, b, res;
    logic         carry, zero;
  } vec_t;
  vec_t vecs[6];

  logic [W:0]   exp_q[$];
  logic         stall_prev = 1'b0, held_c, held_z;
  logic [W-1:0] held_out;

  pipelined_mantissa_adder #(.WIDTH(W), .STAGES(3)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_carry(out_carry), .out_zero(out_zero)
  );

  always #5 in_clk = ~in_clk;

  // Reference: plain integer arithmetic; for subtraction carry means "no borrow".
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    if (sub) return {a >= b, a - b};
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom % 8)
      0: return '0;
      1: return '1;
      2: return 24'h800000;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  // Scoreboard: inputs/outputs are stable at negedge and show what the next edge transfers.
  always @(negedge in_clk) begin
    if (in_rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_out", out, held_out);
        chk("hold_carry", out_carry, held_c);
        chk("hold_zero", out_zero, held_z);
        chk("hold_valid", out_valid, 1);
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out: got %0h want none", out);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          chk("sb_out", out, e[W-1:0]);
          chk("sb_carry", out_carry, e[W]);
          chk("sb_zero", out_zero, e[W-1:0] == '0);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_sub));
      stall_prev = out_valid && !out_ready;
      held_out   = out;
      held_c     = out_carry;
      held_z     = out_zero;
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, guard, n0, sent, cyc;
    logic acc;
    vecs[0] = '{1'b0, 24'h00FFFF, 24'h000001, 24'h010000, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 24'hFFFFFF, 24'h000001, 24'h000000, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 24'h800000, 24'h800000, 24'h000000, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 24'h400000, 24'h000001, 24'h3FFFFF, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 24'h000001, 24'h000002, 24'hFFFFFF, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 24'h123456, 24'h123456, 24'h000000, 1'b1, 1'b1};

    repeat (2) tick();
    in_rst = 1'b0;
    @(negedge in_clk);
    chk("reset_valid", out_valid, 0);
    chk("reset_ready", in_ready, 1);
    chk("reset_out", out, 0);
    chk("reset_carry", out_carry, 0);
    chk("reset_zero", out_zero, 0);
    tick();

    foreach (vecs[i]) begin
      in_valid = 1'b1;
      in_sub   = vecs[i].sub;
      in_a     = vecs[i].a;
      in_b     = vecs[i].b;
      tick();
      in_valid = 1'b0;
      lat = 0;
      do begin
        @(negedge in_clk);
        lat++;
      end while (!out_valid && lat < 10);
      chk($sformatf("vec%0d_latency", i), lat, 3);
      chk($sformatf("vec%0d_out", i), out, vecs[i].res);
      chk($sformatf("vec%0d_carry", i), out_carry, vecs[i].carry);
      chk($sformatf("vec%0d_zero", i), out_zero, vecs[i].zero);
      tick();
    end

    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          in_valid = 1'b1;
          in_sub   = 1'($urandom);
          in_a     = W'($urandom);
          in_b     = W'($urandom);
          do begin
            @(negedge in_clk);
            acc = in_ready;
            @(posedge in_clk);
            #1;
          end while (!acc);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (4) tick();
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge in_clk);
          chk("stall_in_ready", in_ready, 0);
          chk("stall_out_valid", out_valid, 1);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      tick();
      guard++;
    end
    chk("stream_drain", exp_q.size(), 0);
    chk("stream_count", n_out - n0, 8);

    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_sub   = 1'($urandom);
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      in_rst   = (i == 2);
      tick();
    end
    in_rst   = 1'b0;
    in_valid = 1'b0;
    @(negedge in_clk);
    chk("rst_flight_valid", out_valid, 0);
    chk("rst_flight_ready", in_ready, 1);
    repeat (5) begin
      @(negedge in_clk);
      chk("rst_no_stale", out_valid, 0);
    end
    tick();

    sent = 0;
    cyc  = 0;
    while (sent < 10000 && cyc < 60000) begin
      in_valid  = ($urandom % 10) < 7;
      in_sub    = 1'($urandom);
      in_a      = pick();
      in_b      = ($urandom % 16 == 0) ? in_a : pick();
      out_ready = ($urandom % 10) < 7;
      @(negedge in_clk);
      acc = in_valid && in_ready;
      @(posedge in_clk);
      #1;
      sent += int'(acc);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      tick();
      guard++;
    end
    chk("random_sent", sent, 10000);
    chk("random_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
